mitll_xort_sync: RTL and testbench
==================================

Name: mitll_xort_sync

Overview:
- Cycle-accurate synchronous emulation of the MITLL RSFQ clocked XOR cell (XORT) for digital simulation and FPGA prototyping.
- Data and SFQ-clock inputs are toggle-encoded: each level transition is one SFQ pulse.
- On each SFQ clock pulse, an output pulse (a toggle of `out`) is emitted if exactly one data input pulsed since the previous SFQ clock pulse.
- Sits between toggle-encoded RSFQ logic models inside a clocked harness.

Parameters:
- OUT_DELAY, 1, system-clock cycles from SFQ-clock edge detection to the `out` toggle; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  data input A; every transition is one pulse; synchronous to clk.
- b  input  1  data input B; every transition is one pulse; synchronous to clk.
- sfq_clk  input  1  SFQ clock input; every transition is one clock pulse.
- out  output  1  XOR result; toggles once per emitted output pulse.
- state_o  output  2  internal state: 0 = S0, 1 = S1, 2 = S2.
- dup_o  output  1  one-cycle flag: a redundant data pulse was absorbed.

Behaviour:
- Edge detect: registers a_q, b_q, c_q. Pulse events are ea = a^a_q, eb = b^b_q, ec = sfq_clk^c_q.
- During rst, a_q/b_q/c_q load the current input levels. Releasing reset therefore never creates a phantom pulse.
- Reset values: state = S0, out = 0, dup_o = 0, output delay pipeline cleared.
- States:
  - S0: no data pulse stored.
  - S1: exactly one data pulse stored (from either input).
  - S2: pulses on both inputs stored (XOR = 0).
- Data transitions when ec = 0:
  - S0: ea XOR eb → S1; ea AND eb in the same cycle → S2; neither → stay S0.
  - S1: a second pulse on the same input as before → stay S1, assert dup_o. A pulse on the other input → S2. Both in one cycle → S2, assert dup_o.
  - The state records which input fed S1, so "same" vs "other" can be told apart.
  - S2: any data pulse → stay S2, assert dup_o.
- SFQ clock (ec = 1):
  - Evaluate the state registered before this cycle.
  - If it is S1, push a toggle request into the delay pipeline.
  - State clears to S0. Any ea/eb in the same cycle is then applied from S0 (e.g. ec with ea → S1).
  - dup_o never asserts in an ec cycle.
- Output: the pipeline is OUT_DELAY stages deep. When a request reaches the final stage, out <= ~out.
  - Latency is exactly OUT_DELAY cycles after the cycle in which ec is detected.
- Pulse accounting: at most one output pulse per SFQ clock pulse. No pulses are lost in the pipeline; back-to-back ec cycles each produce an independent request.
- rst mid-operation: pending pipeline requests are discarded, state returns to S0, out returns to 0.
- state_o reports S0/S1/S2 only. Value 3 is never produced.

Decomposition:
- Shared package `rsfq_pkg`:
  - xort_state_t enum: S0, S1_A, S1_B, S2. state_o maps S1_A and S1_B both to 1.
  - Constant MAX_OUT_DELAY = 16.
- One natural sub-module, `sfq_toggle_edge`: register plus XOR edge detector with reset-load behaviour. Instantiate it three times.
- The delay pipeline stays inline.

Test Plan:
- Reset, then a toggles at cycles 2 and 3, sfq_clk toggles at cycle 5 → S1 after cycle 2; dup_o = 1 at cycle 3; out 0 → 1 at cycle 5 + OUT_DELAY; state S0 afterwards.
- b toggles at cycles 6 and 7, a toggles at cycle 8, sfq_clk toggles at cycle 9 → dup_o at cycle 7; S2 at cycle 8; out stays unchanged; S0 after cycle 9.
- a and b toggle in the same cycle, then sfq_clk → direct S0 → S2; no out toggle.
- sfq_clk toggles with no data pulses for 4 consecutive cycles → out never toggles; state stays S0.
- With OUT_DELAY = 3: one a pulse, then sfq_clk in the same cycle as a new b pulse → out toggles exactly 3 cycles later; state = S1 from the b pulse. A following sfq_clk then produces a second toggle.
- Assert rst one cycle after an S1 clock pulse, with OUT_DELAY = 3 → no out toggle; out = 0; state S0; no pulse is generated by the input levels present at reset release.

Source files
------------

// File: rtl/rsfq_pkg.sv
// Shared types and helpers for the toggle-encoded RSFQ cell models.
// The XORT state and its data-pulse transition rule live here so that models stay consistent.
package rsfq_pkg;

  localparam int unsigned MAX_OUT_DELAY = 16;

  // S1 is split by source so a repeat pulse on the same input can be recognised as redundant.
  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1_A = 2'd1,
    S1_B = 2'd2,
    S2   = 2'd3
  } xort_state_t;

  typedef struct packed {
    xort_state_t nxt;
    logic        dup;
  } xort_step_t;

  // Applies this cycle's data pulses to a starting state.
  function automatic xort_step_t xort_step(xort_state_t s, logic ea, logic eb);
    xort_step_t r;
    r.nxt = s;
    r.dup = 1'b0;
    unique case (s)
      S0: begin
        if (ea && eb)  r.nxt = S2;
        else if (ea)   r.nxt = S1_A;
        else if (eb)   r.nxt = S1_B;
      end
      S1_A: begin
        if (eb) begin
          r.nxt = S2;
          r.dup = ea;
        end else if (ea) begin
          r.dup = 1'b1;
        end
      end
      S1_B: begin
        if (ea) begin
          r.nxt = S2;
          r.dup = eb;
        end else if (eb) begin
          r.dup = 1'b1;
        end
      end
      S2: r.dup = ea | eb;
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

  // External state code: both S1 flavours report as 1, so 3 never appears.
  function automatic logic [1:0] state_code(xort_state_t s);
    logic [1:0] c;
    c = 2'd0;
    unique case (s)
      S0:          c = 2'd0;
      S1_A, S1_B:  c = 2'd1;
      S2:          c = 2'd2;
      default:     c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sfq_toggle_edge.sv
// Toggle-to-pulse converter: one registered copy of the input level, XORed with the live level.
// During reset the register tracks the input, so leaving reset never yields a phantom pulse.
module sfq_toggle_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_pulse
);

  logic r_q;

  // NOTE: non-blocking assignment for every flop, so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    r_q <= i_din;
  end

  assign o_pulse = ~rst & (i_din ^ r_q);

endmodule

// File: rtl/mitll_xort_sync.sv
// Cycle-accurate clocked XOR (XORT) model: stores data pulses between SFQ clock pulses and
// emits an output toggle OUT_DELAY cycles after a clock pulse that found exactly one stored.
module mitll_xort_sync
  import rsfq_pkg::*;
#(
  parameter int unsigned OUT_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       sfq_clk,
  output logic       out,
  output logic [1:0] state_o,
  output logic       dup_o
);

  localparam int unsigned DEPTH = (OUT_DELAY < 1) ? 1 :
                                  (OUT_DELAY > MAX_OUT_DELAY) ? MAX_OUT_DELAY : OUT_DELAY;

  logic        w_ea;
  logic        w_eb;
  logic        w_ec;
  logic        w_push;
  xort_step_t  w_step;

  xort_state_t      r_state;
  logic             r_out;
  logic             r_dup;
  logic [DEPTH-1:0] r_pipe;

  sfq_toggle_edge u_edge_a (.clk(clk), .rst(rst), .i_din(a),       .o_pulse(w_ea));
  sfq_toggle_edge u_edge_b (.clk(clk), .rst(rst), .i_din(b),       .o_pulse(w_eb));
  sfq_toggle_edge u_edge_c (.clk(clk), .rst(rst), .i_din(sfq_clk), .o_pulse(w_ec));

  // A clock pulse reads the pre-cycle state, then data pulses in the same cycle start over from S0.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_push = 1'b0;
    w_step = xort_step(r_state, w_ea, w_eb);
    if (w_ec) begin
      w_push = (r_state == S1_A) || (r_state == S1_B);
      w_step = xort_step(S0, w_ea, w_eb);
    end
  end

  // NOTE: the delay pipeline is cleared on reset so requests in flight are discarded, not replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_dup   <= 1'b0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_step.nxt;
      r_dup   <= w_step.dup;
      if (r_pipe[DEPTH-1]) r_out <= ~r_out;
    end
  end

  generate
    if (DEPTH == 1) begin : g_pipe_1
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= w_push;
      end
    end else begin : g_pipe_n
      always_ff @(posedge clk) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[DEPTH-2:0], w_push};
      end
    end
  endgenerate

  assign out     = r_out;
  assign state_o = state_code(r_state);
  assign dup_o   = r_dup;

endmodule

// File: tb/tb_mitll_xort_sync.sv
// Directed bench for mitll_xort_sync: two instances (OUT_DELAY 1 and 3) share the same stimulus.
// Each step compares {state, dup, out} of both against hand-computed values.
module tb_mitll_xort_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic       b;
  logic       sfq_clk;
  logic       out1, out3;
  logic [1:0] st1, st3;
  logic       dup1, dup3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mitll_xort_sync #(.OUT_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sfq_clk(sfq_clk),
    .out(out1), .state_o(st1), .dup_o(dup1)
  );

  mitll_xort_sync #(.OUT_DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .sfq_clk(sfq_clk),
    .out(out3), .state_o(st3), .dup_o(dup3)
  );

  // Sample one time unit after the rising edge; inputs are changed at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {st1, dup1, out1, st3, dup3, out3};
  endfunction

  // Both instances share stimulus, so they agree on state and dup; only out timing differs.
  function automatic logic [7:0] ex(logic [1:0] st, logic dup, logic o1, logic o3);
    return {st, dup, o1, st, dup, o3};
  endfunction

  task automatic test_reset();
    logic [7:0] got, want;
    rst = 1'b1; a = 1'b0; b = 1'b0; sfq_clk = 1'b0;
    step(); step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_held: got %b want %b", got, want); end
    rst = 1'b0;
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_release: got %b want %b", got, want); end
  endtask

  task automatic test_single_a();
    logic [7:0] got, want;
    a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_a_first: got %b want %b", got, want); end
    a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b1, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_a_dup: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_dup_clear: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_clk: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_out_d1: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_out_d3_wait: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t1_out_d3: got %b want %b", got, want); end
  endtask

  task automatic test_both_inputs();
    logic [7:0] got, want;
    b = ~b; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t2_b_first: got %b want %b", got, want); end
    b = ~b; step();
    got = obs(); want = ex(2'd1, 1'b1, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t2_b_dup: got %b want %b", got, want); end
    a = ~a; step();
    got = obs(); want = ex(2'd2, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t2_a_to_s2: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t2_clk: got %b want %b", got, want); end
    for (int i = 0; i < 4; i++) begin
      step();
      got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL t2_no_toggle[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] got, want;
    a = ~a; b = ~b; step();
    got = obs(); want = ex(2'd2, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t3_ab_s2: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t3_clk: got %b want %b", got, want); end
    for (int i = 0; i < 4; i++) begin
      step();
      got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL t3_no_toggle[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_idle_clock();
    logic [7:0] got, want;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) sfq_clk = ~sfq_clk;
      step();
      got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL t4_idle_clk[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_delay3();
    logic [7:0] got, want;
    a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_a: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; b = ~b; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_clk_b: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b0, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_e1: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b0, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_e2: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_e3: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_clk2: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_clk2_e1: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_clk2_e2: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t5_clk2_e3: got %b want %b", got, want); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, want;
    a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_a: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_clk_a_no_dup: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_clk2: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_e2: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b0); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_e3: got %b want %b", got, want); end
    step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t6_e4: got %b want %b", got, want); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] got, want;
    a = ~a; step();
    got = obs(); want = ex(2'd1, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t7_a: got %b want %b", got, want); end
    sfq_clk = ~sfq_clk; step();
    got = obs(); want = ex(2'd0, 1'b0, 1'b1, 1'b1); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL t7_clk: got %b want %b", got, want); end
    rst = 1'b1; a = ~a; b = ~b; sfq_clk = ~sfq_clk;
    for (int i = 0; i < 4; i++) begin
      step();
      got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL t7_in_reset[%0d]: got %b want %b", i, got, want); end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      got = obs(); want = ex(2'd0, 1'b0, 1'b0, 1'b0); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL t7_after_reset[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_both_inputs();
    test_simultaneous();
    test_idle_clock();
    test_delay3();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
